// File: rtl/fp_inv_sqrt_unit_if.sv
// Operand/result handshake bundle for the fixed-point 1/sqrt unit.
// The master side is the sequencer. The slave side is the unit.
interface fp_inv_sqrt_unit_if #(
    parameter int WIDTH = 32
);
    logic                    valid_in;
    logic                    ready_out;
    logic signed [WIDTH-1:0] x_in;
    logic                    valid_out;
    logic                    ready_in;
    logic signed [WIDTH-1:0] res_out;
    logic                    err_out;

    modport master (
        output valid_in, x_in, ready_in,
        input  ready_out, valid_out, res_out, err_out
    );

    modport slave (
        input  valid_in, x_in, ready_in,
        output ready_out, valid_out, res_out, err_out
    );
endinterface

// File: rtl/fp_inv_sqrt_unit.sv
// Multi-cycle fixed-point 1/sqrt(x) unit.
// It forms a leading-one seed, then runs ITERS Newton-Raphson steps
// y' = y*(1.5 - 0.5*x*y*y) on a single shared multiplier.
// Latency is a constant 3*ITERS+2 cycles from accept to valid_out.
// The error path (x <= 0) also uses this latency.
module fp_inv_sqrt_unit #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16,
    parameter int ITERS     = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    fp_inv_sqrt_unit_if.slave bus
);
    localparam int IW  = 2 * WIDTH;      // width of the y/t intermediates
    localparam int PW  = 4 * WIDTH;      // full product width
    // y and t carry FRAC_BITS extra guard bits. This keeps small results
    // (large x) from stalling on truncation inside the iteration.
    localparam int IFB = 2 * FRAC_BITS;

    localparam logic signed [IW-1:0] THREE_HALVES = {{(IW-2){1'b0}}, 2'b11} << (IFB - 1);
    localparam logic signed [IW-1:0] RES_MAX      = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, SEED, SQ, XM, UPD, DONE} state_t;

    state_t                  state;
    logic [3:0]              count;
    logic signed [WIDTH-1:0] x;
    logic signed [IW-1:0]    y, t;
    logic                    ready_r, valid_r, err_r;
    logic signed [WIDTH-1:0] res_r;

    logic                    x_err;
    int                      seed_p, seed_sh;
    logic signed [IW-1:0]    y0;
    logic signed [IW-1:0]    mul_a, mul_b, mul_q;
    logic signed [PW-1:0]    prod;
    logic signed [IW-1:0]    y_q;
    logic signed [WIDTH-1:0] y_sat;

    assign x_err = (x <= 0);

    // The seed y0 = 2^-ceil(e/2) is built from the leading-one position of x.
    // The value 1.0 is shifted into the guard-extended format.
    always_comb begin
        seed_p = 0;
        for (int i = 0; i < WIDTH; i++)
            if (x[i]) seed_p = i;
        seed_sh = IFB - ((seed_p - FRAC_BITS + 1) >>> 1);
        y0 = {{(IW-1){1'b0}}, 1'b1} << seed_sh;
    end

    // The operand mux selects the inputs of the one shared multiplier for the current state.
    always_comb begin
        mul_a = y;
        mul_b = y;
        case (state)
            XM: begin
                mul_a = {{WIDTH{x[WIDTH-1]}}, x};
                mul_b = t;
            end
            UPD: begin
                mul_a = y;
                mul_b = THREE_HALVES - (t >>> 1);
            end
            default: ;
        endcase
    end

    assign prod  = $signed({{IW{mul_a[IW-1]}}, mul_a}) * $signed({{IW{mul_b[IW-1]}}, mul_b});
    // x is plain Q.FRAC_BITS. Every other factor carries the guard bits.
    assign mul_q = (state == XM) ? IW'(prod >>> FRAC_BITS) : IW'(prod >>> IFB);

    // The final y drops the guard bits (truncating toward -inf) and is clamped to [0, max positive].
    assign y_q = y >>> FRAC_BITS;
    always_comb begin
        if (y_q < 0)            y_sat = '0;
        else if (y_q > RES_MAX) y_sat = RES_MAX[WIDTH-1:0];
        else                    y_sat = y_q[WIDTH-1:0];
    end

    // Control FSM and datapath registers. Every output is registered.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= IDLE;
            count   <= '0;
            x       <= '0;
            y       <= '0;
            t       <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            res_r   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.valid_in) begin
                    x       <= bus.x_in;
                    ready_r <= 1'b0;
                    state   <= SEED;
                end
                SEED: begin
                    // On a domain error the iteration runs on y=0. It keeps the
                    // schedule and the result is replaced at DONE.
                    y     <= x_err ? '0 : y0;
                    count <= '0;
                    state <= SQ;
                end
                SQ: begin
                    t     <= mul_q;
                    state <= XM;
                end
                XM: begin
                    t     <= mul_q;
                    state <= UPD;
                end
                UPD: begin
                    y     <= mul_q;
                    count <= count + 4'd1;
                    state <= (count == 4'(ITERS - 1)) ? DONE : SQ;
                end
                DONE: begin
                    if (!valid_r) begin
                        valid_r <= 1'b1;
                        err_r   <= x_err;
                        res_r   <= x_err ? RES_MAX[WIDTH-1:0] : y_sat;
                    end else if (bus.ready_in) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_out = ready_r;
    assign bus.valid_out = valid_r;
    assign bus.res_out   = res_r;
    assign bus.err_out   = err_r;
endmodule

// File: tb/tb_fp_inv_sqrt_unit.sv
// Directed and random bench for fp_inv_sqrt_unit.
// The reference is the real-valued 1/sqrt plus the domain-error rule.
module tb_fp_inv_sqrt_unit;
    localparam int LAT = 17;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_inv_sqrt_unit_if #(.WIDTH(32)) bus ();

    fp_inv_sqrt_unit #(.WIDTH(32), .FRAC_BITS(16), .ITERS(5)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input real exact);
        real d;
        d = real'(obs) - exact;
        checks++;
        assert (d <= 2.0 && d >= -2.0) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=%f (+/-2)", tag, obs, exact);
        end
    endtask

    // Reference model: the exact real 1/sqrt in Q15.16, or a domain error.
    function automatic void ref_model(input logic [31:0] x, output bit err, output real exact);
        if ($signed(x) <= 0) begin
            err   = 1'b1;
            exact = 2147483647.0;
        end else begin
            err   = 1'b0;
            exact = 65536.0 / $sqrt(real'($signed(x)) / 65536.0);
        end
    endfunction

    // Waits for ready_out, presents one operand and returns just after the accept edge.
    task automatic start_op(input logic [31:0] x);
        for (int i = 0; i < 50 && !bus.ready_out; i++) @(posedge clk) #1;
        chk_eq("ready_before_accept", longint'(bus.ready_out), 1);
        bus.valid_in = 1'b1;
        bus.x_in     = x;
        @(posedge clk) #1;
        bus.valid_in = 1'b0;
        bus.x_in     = $urandom;
    endtask

    // Counts cycles from accept to valid_out. The wait is bounded.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!bus.valid_out && lat < 100) begin
            @(posedge clk) #1;
            lat++;
        end
        chk_eq({tag, "_latency"}, longint'(lat), LAT);
    endtask

    // Runs one full operation with ready_in high.
    // It checks latency, the result against the model and the handoff.
    task automatic run_op(input string tag, input logic [31:0] x,
                          output logic [31:0] res, output logic err);
        int  lat;
        bit  e_err;
        real e_val;
        ref_model(x, e_err, e_val);
        bus.ready_in = 1'b1;
        start_op(x);
        wait_valid(tag, lat);
        res = bus.res_out;
        err = bus.err_out;
        chk_eq({tag, "_err"}, longint'(err), longint'(e_err));
        if (e_err) chk_eq({tag, "_res"}, longint'(res), 64'h7FFF_FFFF);
        else       chk_near({tag, "_res"}, res, e_val);
        @(posedge clk) #1;
        chk_eq({tag, "_handoff_valid"}, longint'(bus.valid_out), 0);
        chk_eq({tag, "_handoff_ready"}, longint'(bus.ready_out), 1);
    endtask

    initial begin
        logic [31:0] r, held, x;
        logic        e;
        int          lat;
        bit          saw;

        // Reset state
        rst = 1'b1; bus.valid_in = 1'b0; bus.ready_in = 1'b1; bus.x_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_ready", longint'(bus.ready_out), 1);
        chk_eq("rst_valid", longint'(bus.valid_out), 0);
        chk_eq("rst_res",   longint'(bus.res_out),   0);
        chk_eq("rst_err",   longint'(bus.err_out),   0);
        rst = 1'b0;
        @(posedge clk) #1;

        // Directed values
        run_op("one", 32'h0001_0000, r, e);
        run_op("four", 32'h0004_0000, r, e);
        chk_eq("four_exact", longint'(r), 32'h0000_8000);
        run_op("quarter", 32'h0000_4000, r, e);
        chk_eq("quarter_exact", longint'(r), 32'h0002_0000);
        run_op("two", 32'h0002_0000, r, e);
        run_op("min_lsb", 32'h0000_0001, r, e);
        chk_eq("min_lsb_exact", longint'(r), 32'h0100_0000);
        run_op("max_pos", 32'h7FFF_FFFF, r, e);
        run_op("zero", 32'h0000_0000, r, e);
        run_op("neg_one", 32'hFFFF_0000, r, e);
        run_op("min_neg", 32'h8000_0000, r, e);

        // Backpressure: the result is held for 10 cycles and busy-time valid_in pulses are ignored.
        bus.ready_in = 1'b0;
        start_op(32'h0009_0000);
        wait_valid("bp", lat);
        held = bus.res_out;
        chk_eq("bp_res", longint'(held), 32'h0000_5555);
        for (int i = 0; i < 10; i++) begin
            bus.valid_in = 1'b1; bus.x_in = 32'h0001_0000;
            @(posedge clk) #1;
            bus.valid_in = 1'b0;
            chk_eq("bp_valid_held", longint'(bus.valid_out), 1);
            chk_eq("bp_res_stable", longint'(bus.res_out), longint'(held));
            chk_eq("bp_ready_low",  longint'(bus.ready_out), 0);
        end
        bus.ready_in = 1'b1;
        @(posedge clk) #1;
        chk_eq("bp_release_valid", longint'(bus.valid_out), 0);
        chk_eq("bp_release_ready", longint'(bus.ready_out), 1);
        chk_eq("bp_res_kept",      longint'(bus.res_out), longint'(held));

        // Reset during an operation: it wins over a simultaneous valid_in and produces no valid_out.
        start_op(32'h0003_0000);
        repeat (7) @(posedge clk) #1;
        rst = 1'b1; bus.valid_in = 1'b1; bus.x_in = 32'h0001_0000;
        @(posedge clk) #1;
        rst = 1'b0; bus.valid_in = 1'b0;
        chk_eq("midrst_ready", longint'(bus.ready_out), 1);
        chk_eq("midrst_valid", longint'(bus.valid_out), 0);
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk) #1;
            if (bus.valid_out) saw = 1'b1;
        end
        chk_eq("midrst_no_pulse", longint'(saw), 0);
        run_op("post_rst_four", 32'h0004_0000, r, e);
        chk_eq("post_rst_exact", longint'(r), 32'h0000_8000);

        // Random sweep over magnitudes, with occasional non-positive operands.
        for (int n = 0; n < 24; n++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 5) != 0) x[31] = 1'b0;
            run_op("rand", x, r, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
